// File: rtl/str_esc_pkg.sv
// Shared types, ASCII constants and character-class helpers
// for the string-literal escape decoder.
package str_esc_pkg;

   typedef enum logic [2:0] {
      NORM, ESC, OCT1, OCT2, HEX0, HEX1
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE  = 2'd0,
      ERR_HEX   = 2'd1,
      ERR_TRAIL = 2'd2
   } err_t;

   localparam logic [7:0] CH_BSL = 8'h5C;
   localparam logic [7:0] CH_DQ  = 8'h22;
   localparam logic [7:0] CH_X   = 8'h78;
   localparam logic [7:0] CH_N   = 8'h6E;
   localparam logic [7:0] CH_T   = 8'h74;
   localparam logic [7:0] CH_A   = 8'h61;
   localparam logic [7:0] CH_F   = 8'h66;
   localparam logic [7:0] CH_V   = 8'h76;

   function automatic logic is_oct(input logic [7:0] c);
      return (c >= 8'h30) && (c <= 8'h37);
   endfunction

   function automatic logic is_hex(input logic [7:0] c);
      return ((c >= 8'h30) && (c <= 8'h39)) ||
             ((c >= 8'h61) && (c <= 8'h66)) ||
             ((c >= 8'h41) && (c <= 8'h46));
   endfunction

   function automatic logic [3:0] hex_val(input logic [7:0] c);
      logic [7:0] t;
      if (c <= 8'h39)      t = c - 8'h30;
      else if (c >= 8'h61) t = c - 8'h57;
      else                 t = c - 8'h37;
      return t[3:0];
   endfunction

endpackage

// File: rtl/str_esc_fifo.sv
// Synchronous FIFO of {last, char} entries feeding the
// decoder's output handshake.
module str_esc_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic [8:0] wdata,
   input  logic       pop,
   output logic [8:0] rdata,
   output logic       full,
   output logic       empty
);

   localparam int AW = $clog2(DEPTH);

   logic [8:0]  mem [DEPTH];
   logic [AW:0] wp;
   logic [AW:0] rp;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp <= '0;
         rp <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push && !full) begin
            mem[wp[AW-1:0]] <= wdata;
            wp <= wp + (AW+1)'(1);
         end
         if (pop && !empty) rp <= rp + (AW+1)'(1);
      end
   end

   // extra pointer bit tells full from empty
   assign empty = (wp == rp);
   assign full  = (wp[AW] != rp[AW]) &&
                  (wp[AW-1:0] == rp[AW-1:0]);
   assign rdata = mem[rp[AW-1:0]];

endmodule

// File: rtl/str_escape_decoder.sv
// Streaming decoder for SystemVerilog string-literal bodies:
// resolves named, octal, hex and stray backslash escapes.
module str_escape_decoder
   import str_esc_pkg::*;
#(
   parameter int STRICT     = 1,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_char,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_char,
   output logic             out_last,
   output logic [1:0]       err_code,
   output logic [CNT_W-1:0] lit_count
);

   state_t     state, nstate;
   logic [7:0] acc, nacc;
   err_t       nerr;
   logic       term, replay, full, empty;
   logic       push, plast;
   logic [7:0] pchar, esc_char, oct_acc, hex_acc;
   logic [8:0] rdata;

   assign oct_acc = {acc[4:0], in_char[2:0]};
   assign hex_acc = {acc[3:0], hex_val(in_char)};

   always_comb begin
      esc_char = in_char;
      case (in_char)
         CH_N:    esc_char = 8'h0A;
         CH_T:    esc_char = 8'h09;
         CH_A:    esc_char = (STRICT != 0) ? 8'h07 : CH_A;
         CH_F:    esc_char = (STRICT != 0) ? 8'h0C : CH_F;
         CH_V:    esc_char = (STRICT != 0) ? 8'h0B : CH_V;
         default: esc_char = in_char;
      endcase
   end

   // a non-digit ends a numeric escape without being consumed
   always_comb begin
      term = 1'b0;
      unique case (state)
         OCT1, OCT2: term = !is_oct(in_char);
         HEX0, HEX1: term = !is_hex(in_char);
         default:    term = 1'b0;
      endcase
   end

   assign replay   = in_valid && term;
   assign in_ready = !full && !replay;

   always_comb begin
      nstate = state;
      nacc   = acc;
      nerr   = ERR_NONE;
      push   = 1'b0;
      pchar  = in_char;
      plast  = in_last;
      if (in_valid && !full) begin
         unique case (state)
            NORM: begin
               if (in_char == CH_BSL) begin
                  if (in_last) begin
                     push = 1'b1;
                     nerr = ERR_TRAIL;
                  end else begin
                     nstate = ESC;
                  end
               end else begin
                  push = 1'b1;
               end
            end
            ESC: begin
               nstate = NORM;
               if (is_oct(in_char)) begin
                  nacc = {5'd0, in_char[2:0]};
                  if (in_last) begin
                     push  = 1'b1;
                     pchar = {5'd0, in_char[2:0]};
                  end else begin
                     nstate = OCT1;
                  end
               end else if (in_char == CH_X) begin
                  if (in_last) push = 1'b1;
                  else nstate = HEX0;
               end else begin
                  push  = 1'b1;
                  pchar = esc_char;
               end
            end
            OCT1: begin
               nstate = NORM;
               if (term) begin
                  push  = 1'b1;
                  pchar = acc;
                  plast = 1'b0;
               end else if (in_last) begin
                  push  = 1'b1;
                  pchar = oct_acc;
               end else begin
                  nacc   = oct_acc;
                  nstate = OCT2;
               end
            end
            OCT2: begin
               nstate = NORM;
               push   = 1'b1;
               pchar  = term ? acc : oct_acc;
               plast  = !term && in_last;
            end
            HEX0: begin
               nstate = NORM;
               if (term) begin
                  push  = 1'b1;
                  pchar = CH_X;
                  plast = 1'b0;
                  nerr  = ERR_HEX;
               end else if (in_last) begin
                  push  = 1'b1;
                  pchar = {4'd0, hex_val(in_char)};
               end else begin
                  nacc   = {4'd0, hex_val(in_char)};
                  nstate = HEX1;
               end
            end
            HEX1: begin
               nstate = NORM;
               push   = 1'b1;
               pchar  = term ? acc : hex_acc;
               plast  = !term && in_last;
            end
            default: nstate = NORM;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= NORM;
         acc       <= '0;
         err_code  <= ERR_NONE;
         lit_count <= '0;
      end else begin
         state    <= nstate;
         acc      <= nacc;
         err_code <= nerr;
         if (out_valid && out_ready && out_last)
            lit_count <= lit_count + CNT_W'(1);
      end
   end

   str_esc_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata ({plast, pchar}),
      .pop   (out_ready && !empty),
      .rdata (rdata),
      .full  (full),
      .empty (empty)
   );

   assign out_valid = !empty;
   assign out_char  = rdata[7:0];
   assign out_last  = rdata[8];

endmodule

// File: tb/tb_str_escape_decoder.sv
// Vector table, hand-written corner sequences and random literals
// checked against a string-level escape model.
module tb_str_escape_decoder;

   typedef logic [7:0] bq_t[$];
   typedef logic [8:0] oq_t[$];
   typedef int         iq_t[$];

   typedef struct {
      string       raw;
      int          n;
      logic [63:0] exp;
      logic [63:0] leg;
      int          err;
      int          stl;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_last, out_ready;
   logic [7:0]  in_char;
   logic        in_ready, out_valid, out_last;
   logic [7:0]  out_char;
   logic [1:0]  err_code;
   logic [15:0] lit_count;
   logic        l_in_ready, l_out_valid, l_out_last;
   logic [7:0]  l_out_char;
   logic [1:0]  l_err;
   logic [15:0] l_cnt;

   oq_t got, lgot;
   iq_t errs;
   int  ncmp = 0, nfail = 0;
   int  stalls = 0, accepted = 0;
   int  mode = 0;
   int  exp_lits = 0;
   bit  sdone;

   always #5 clk = ~clk;

   str_escape_decoder #(.STRICT(1), .FIFO_DEPTH(4), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_char(in_char), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_char(out_char), .out_last(out_last),
      .err_code(err_code), .lit_count(lit_count)
   );

   str_escape_decoder #(.STRICT(0), .FIFO_DEPTH(4), .CNT_W(16)) u_leg (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(l_in_ready),
      .in_char(in_char), .in_last(in_last),
      .out_valid(l_out_valid), .out_ready(out_ready),
      .out_char(l_out_char), .out_last(l_out_last),
      .err_code(l_err), .lit_count(l_cnt)
   );

   always @(posedge clk) begin
      #1;
      if (mode == 0)      out_ready = 1'b1;
      else if (mode == 2) out_ready = 1'b0;
      else                out_ready = ($urandom_range(0, 3) != 0);
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid && out_ready) got.push_back({out_last, out_char});
         if (l_out_valid && out_ready) lgot.push_back({l_out_last, l_out_char});
         if (err_code != 2'd0) errs.push_back(int'(err_code));
         if (in_valid && !in_ready) stalls++;
         if (in_valid && in_ready) accepted++;
      end
   end

   function automatic bit m_oct(input logic [7:0] c);
      return c >= "0" && c <= "7";
   endfunction

   function automatic bit m_hex(input logic [7:0] c);
      return (c >= "0" && c <= "9") || (c >= "a" && c <= "f") ||
             (c >= "A" && c <= "F");
   endfunction

   function automatic int m_hv(input logic [7:0] c);
      if (c <= "9") return int'(c) - 48;
      if (c >= "a") return int'(c) - 87;
      return int'(c) - 55;
   endfunction

   // decode a whole literal the way a string parser would
   function automatic void model(input bq_t l, input bit strict,
                                 output oq_t o, output iq_t e);
      int i, n, v, k;
      logic [7:0] c, d, r;
      o = {};
      e = {};
      i = 0;
      n = l.size();
      while (i < n) begin
         c = l[i];
         if (c != "\\") begin
            o.push_back({1'b0, c});
            i++;
         end else if (i == n - 1) begin
            o.push_back({1'b0, 8'h5C});
            e.push_back(2);
            i++;
         end else begin
            d = l[i+1];
            i += 2;
            if (m_oct(d)) begin
               v = int'(d) - 48;
               k = 1;
               while (k < 3 && i < n && m_oct(l[i])) begin
                  v = v * 8 + int'(l[i]) - 48;
                  i++;
                  k++;
               end
               o.push_back({1'b0, v[7:0]});
            end else if (d == "x") begin
               if (i < n && m_hex(l[i])) begin
                  v = m_hv(l[i]);
                  i++;
                  if (i < n && m_hex(l[i])) begin
                     v = v * 16 + m_hv(l[i]);
                     i++;
                  end
                  o.push_back({1'b0, v[7:0]});
               end else begin
                  o.push_back({1'b0, 8'h78});
                  if (i < n) e.push_back(1);
               end
            end else begin
               case (d)
                  "n":     r = 8'h0A;
                  "t":     r = 8'h09;
                  "a":     r = strict ? 8'h07 : 8'h61;
                  "f":     r = strict ? 8'h0C : 8'h66;
                  "v":     r = strict ? 8'h0B : 8'h76;
                  default: r = d;
               endcase
               o.push_back({1'b0, r});
            end
         end
      end
      if (o.size() > 0) o[o.size()-1][8] = 1'b1;
   endfunction

   function automatic bq_t s2q(input string s);
      bq_t q;
      for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
      return q;
   endfunction

   function automatic vec_t mk(input string raw, input int n,
                               input logic [63:0] exp, input logic [63:0] leg,
                               input int err, input int stl);
      vec_t v;
      v.raw = raw; v.n = n; v.exp = exp; v.leg = leg;
      v.err = err; v.stl = stl;
      return v;
   endfunction

   function automatic oq_t unpack(input logic [63:0] p, input int n);
      oq_t q;
      for (int k = 0; k < n; k++) q.push_back({k == n - 1, p[8*k +: 8]});
      return q;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      ncmp++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_seq(input string nm, input oq_t g, input oq_t e);
      int bad;
      bad = -1;
      ncmp++;
      if (g.size() != e.size()) bad = 0;
      else
         for (int k = 0; k < e.size(); k++)
            if (bad < 0 && g[k] !== e[k]) bad = k;
      if (bad >= 0) begin
         nfail++;
         if (g.size() != e.size())
            $display("FAIL %s: got %0d bytes expected %0d", nm, g.size(), e.size());
         else
            $display("FAIL %s: byte %0d got %h expected %h", nm, bad, g[bad], e[bad]);
      end
   endtask

   task automatic send(input bq_t q, input bit last, input int gap);
      int  g;
      logic ok;
      @(posedge clk); #1;
      for (int k = 0; k < q.size(); k++) begin
         if (gap > 0 && $urandom_range(0, 99) < gap) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
         end
         in_valid = 1'b1;
         in_char  = q[k];
         in_last  = last && (k == q.size() - 1);
         g  = 0;
         ok = 1'b0;
         while (!ok && g < 1000) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
            g++;
         end
         if (!ok) begin
            ncmp++;
            nfail++;
            $display("FAIL send_timeout: got no in_ready expected acceptance");
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_out(input int n);
      int g;
      g = 0;
      while (got.size() < n && g < 2000) begin
         @(negedge clk);
         g++;
      end
      if (g >= 2000) begin
         ncmp++;
         nfail++;
         $display("FAIL out_timeout: got %0d bytes expected %0d", got.size(), n);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic clear();
      got.delete();
      lgot.delete();
      errs.delete();
      stalls = 0;
      accepted = 0;
   endtask

   vec_t tbl[10];
   bq_t  lq;
   oq_t  eo, el;
   iq_t  ee, ej;
   string alpha;
   int   a0, g;

   initial begin
      tbl[0] = mk("a\\nb",          3, 64'h620A61,   64'h620A61,   0, 0);
      tbl[1] = mk("\\a\\f\\v",      3, 64'h0B0C07,   64'h766661,   0, 0);
      tbl[2] = mk("\\8\\q",         2, 64'h7138,     64'h7138,     0, 0);
      tbl[3] = mk("\\101\\7z\\777", 4, 64'hFF7A0741, 64'hFF7A0741, 0, 1);
      tbl[4] = mk("\\x4g",          2, 64'h6704,     64'h6704,     0, 1);
      tbl[5] = mk("\\xq",           2, 64'h7178,     64'h7178,     1, 1);
      tbl[6] = mk("ab\\",           3, 64'h5C6261,   64'h5C6261,   2, 0);
      tbl[7] = mk("\\\"\\t\\\\",    3, 64'h5C0922,   64'h5C0922,   0, 0);
      tbl[8] = mk("\\x4F",          1, 64'h4F,       64'h4F,       0, 0);
      tbl[9] = mk("\\12",           1, 64'h0A,       64'h0A,       0, 0);

      rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_char = 8'h00;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_char", out_char, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_err", err_code, 0);
      chk("rst_count", lit_count, 0);
      @(posedge clk); #1 rst = 1'b0;

      for (int t = 0; t < 10; t++) begin
         clear();
         send(s2q(tbl[t].raw), 1'b1, 0);
         exp_lits++;
         wait_out(tbl[t].n);
         chk_seq($sformatf("vec%0d_strict", t), got, unpack(tbl[t].exp, tbl[t].n));
         chk_seq($sformatf("vec%0d_legacy", t), lgot, unpack(tbl[t].leg, tbl[t].n));
         chk($sformatf("vec%0d_err", t),
             errs.size() * 16 + (errs.size() > 0 ? errs[0] : 0),
             tbl[t].err != 0 ? 16 + tbl[t].err : 0);
         chk($sformatf("vec%0d_stall", t), stalls, tbl[t].stl);
         chk($sformatf("vec%0d_count", t), lit_count, exp_lits);
      end

      // back-pressure: four entries fill the buffer
      mode = 2;
      repeat (2) @(posedge clk);
      clear();
      sdone = 1'b0;
      fork
         begin
            send(s2q("uvwxyz"), 1'b1, 0);
            sdone = 1'b1;
         end
      join_none
      repeat (12) @(negedge clk);
      chk("full_accepted", accepted, 4);
      chk("full_in_ready", in_ready, 0);
      chk("full_count", lit_count, exp_lits);
      mode = 0;
      g = 0;
      while (!sdone && g < 500) begin
         @(negedge clk);
         g++;
      end
      chk("full_send_done", sdone, 1);
      exp_lits++;
      wait_out(6);
      chk_seq("full_drain", got, unpack(64'h7A7978777675, 6));
      chk("full_count_after", lit_count, exp_lits);

      // reset in the middle of an octal escape
      clear();
      send(s2q("\\1"), 1'b0, 0);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_count", lit_count, 0);
      @(posedge clk); #1 rst = 1'b0;
      exp_lits = 0;
      clear();
      send(s2q("ab"), 1'b1, 0);
      exp_lits++;
      wait_out(2);
      chk_seq("post_rst", got, unpack(64'h6261, 2));
      chk("post_rst_count", lit_count, exp_lits);

      // random literals, random gaps and consumer stalls
      alpha = "\\\\\\\\x\"nafvtq0123789AFcgz ";
      mode = 1;
      for (int r = 0; r < 60; r++) begin
         lq.delete();
         for (int k = 0; k < $urandom_range(1, 10); k++)
            lq.push_back(alpha[$urandom_range(0, alpha.len() - 1)]);
         model(lq, 1'b1, eo, ee);
         model(lq, 1'b0, el, ej);
         clear();
         send(lq, 1'b1, 30);
         exp_lits++;
         wait_out(eo.size());
         chk_seq($sformatf("rnd%0d_strict", r), got, eo);
         chk_seq($sformatf("rnd%0d_legacy", r), lgot, el);
         ncmp++;
         if (errs != ee) begin
            nfail++;
            $display("FAIL rnd%0d_err: got %0d pulses expected %0d", r, errs.size(), ee.size());
         end
         chk($sformatf("rnd%0d_count", r), lit_count, exp_lits);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
